// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
// Holds the default destination-tag width and the record stored per
// queued fmul result (word, exception bits, destination tag).
package fpu_pkg;

    localparam int TAG_W_DEFAULT = 6;

    typedef struct packed {
        logic [31:0]              y;
        logic                     ovf;
        logic                     udf;
        logic [TAG_W_DEFAULT-1:0] tag;
    } fmul_res_t;

endpackage

// File: rtl/wb_ram.sv
// Writeback-queue storage: DEPTH entries of fmul_res_t.
// Ports:
//   clk   - clock, write on rising edge
//   we    - write enable
//   waddr - write address
//   wdata - entry to write
//   raddr - read address
//   rdata - entry at raddr (asynchronous read)
// Contents are not reset; the owner tracks which entries are valid.
module wb_ram
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PW-1:0]   waddr,
    input  fmul_res_t       wdata,
    input  logic [PW-1:0]   raddr,
    output fmul_res_t       rdata
);

    fmul_res_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read so a freshly written head is visible one cycle
    // after the push without an extra pipeline stage.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fmul_wb_queue.sv
// Writeback queue between the fmul unit and the register file.
// Buffers fmul results in push order, keeps sticky overflow/underflow
// flags, and supports a full flush.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready        - result handshake from fmul
//   in_y, in_ovf, in_udf     - result word and exception bits
//   in_tag                   - destination register tag
//   out_valid/out_ready      - head handshake to register file
//   out_data, out_tag        - head word and tag
//   out_exc                  - head {ovf,udf}
//   flush                    - drop all queued entries
//   flag_clear               - clear sticky flags
//   flag_ovf, flag_udf       - sticky exception flags
//   count                    - current occupancy
// TAG_W must match the tag width baked into fpu_pkg::fmul_res_t.
module fmul_wb_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = fpu_pkg::TAG_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_y,
    input  logic                     in_ovf,
    input  logic                     in_udf,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic [1:0]               out_exc,
    input  logic                     flush,
    input  logic                     flag_clear,
    output logic                     flag_ovf,
    output logic                     flag_udf,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          flag_ovf_reg, flag_ovf_next;
    logic          flag_udf_reg, flag_udf_next;

    logic      push;
    logic      pop;
    fmul_res_t wr_entry;
    fmul_res_t rd_entry;

    // in_ready depends only on registered occupancy and flush, never on
    // out_ready, so a full queue cannot accept even when popping.
    assign in_ready  = (count_reg < DEPTH_C) && !flush;
    assign out_valid = (count_reg != '0);

    assign push = in_valid && in_ready;
    // A pop in the flush cycle is irrelevant: the queue empties anyway.
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        flag_ovf_next = flag_ovf_reg;
        flag_udf_next = flag_udf_reg;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end

        // Setting from an accepted push wins over a same-cycle clear.
        if (flag_clear) begin
            flag_ovf_next = 1'b0;
            flag_udf_next = 1'b0;
        end
        if (push) begin
            flag_ovf_next = flag_ovf_next | in_ovf;
            flag_udf_next = flag_udf_next | in_udf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            flag_ovf_reg <= 1'b0;
            flag_udf_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            flag_ovf_reg <= flag_ovf_next;
            flag_udf_reg <= flag_udf_next;
        end
    end

    always_comb begin
        wr_entry     = '0;
        wr_entry.y   = in_y;
        wr_entry.ovf = in_ovf;
        wr_entry.udf = in_udf;
        wr_entry.tag = in_tag;
    end

    wb_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr_reg),
        .wdata (wr_entry),
        .raddr (rd_ptr_reg),
        .rdata (rd_entry)
    );

    assign out_data = rd_entry.y;
    assign out_tag  = rd_entry.tag;
    assign out_exc  = {rd_entry.ovf, rd_entry.udf};
    assign flag_ovf = flag_ovf_reg;
    assign flag_udf = flag_udf_reg;
    assign count    = count_reg;

endmodule

// File: tb/tb_fmul_wb_queue.sv
// Bench for fmul_wb_queue: table of per-cycle vectors with hand-derived
// post-edge expectations, plus a reference queue that predicts every
// head word, tag, exception pair and handshake level.
module tb_fmul_wb_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ovf, in_udf, out_ready, flush, flag_clear;
    logic [31:0]       in_y;
    logic [TAG_W-1:0]  in_tag;
    logic              in_ready, out_valid, flag_ovf, flag_udf;
    logic [31:0]       out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [1:0]        out_exc;
    logic [2:0]        count;

    fmul_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_ovf(in_ovf), .in_udf(in_udf), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_exc(out_exc),
        .flush(flush), .flag_clear(flag_clear),
        .flag_ovf(flag_ovf), .flag_udf(flag_udf), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              in_valid;
        logic [31:0]       y;
        logic              ovf;
        logic              udf;
        logic [TAG_W-1:0]  tag;
        logic              out_ready;
        logic              flush;
        logic              flag_clear;
        int                exp_count;
        logic              exp_ov;
        logic              exp_ir;
        logic              exp_fo;
        logic              exp_fu;
    } vec_t;

    typedef struct {
        logic [31:0]      y;
        logic             ovf;
        logic             udf;
        logic [TAG_W-1:0] tag;
    } sb_t;

    sb_t  sb[$];
    logic fo_m = 1'b0;
    logic fu_m = 1'b0;
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] y,
                                input logic ov, input logic ud, input int tag,
                                input logic ordy, input logic fl, input logic fc,
                                input int ec, input logic eov, input logic eir,
                                input logic efo, input logic efu);
        vec_t v;
        v.rst = r; v.in_valid = iv; v.y = y; v.ovf = ov; v.udf = ud;
        v.tag = TAG_W'(tag); v.out_ready = ordy; v.flush = fl; v.flag_clear = fc;
        v.exp_count = ec; v.exp_ov = eov; v.exp_ir = eir; v.exp_fo = efo; v.exp_fu = efu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs against the reference
    // queue, advance the reference, then check the vector's post-edge values.
    task automatic step(input vec_t v);
        bit push, pop;
        sb_t e;
        rst = v.rst; in_valid = v.in_valid; in_y = v.y; in_ovf = v.ovf;
        in_udf = v.udf; in_tag = v.tag; out_ready = v.out_ready;
        flush = v.flush; flag_clear = v.flag_clear;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("in_ready", 32'(in_ready), 32'((sb.size() < DEPTH) && !v.flush));
        chk("count", 32'(count), sb.size());
        chk("flag_ovf", 32'(flag_ovf), 32'(fo_m));
        chk("flag_udf", 32'(flag_udf), 32'(fu_m));
        if (sb.size() != 0) begin
            chk("out_data", out_data, sb[0].y);
            chk("out_tag", 32'(out_tag), 32'(sb[0].tag));
            chk("out_exc", 32'(out_exc), 32'({sb[0].ovf, sb[0].udf}));
        end
        push = !v.rst && v.in_valid && (sb.size() < DEPTH) && !v.flush;
        pop  = !v.rst && !v.flush && v.out_ready && (sb.size() != 0);
        if (pop) begin
            $display("pop  tag=%0d y=0x%08h exc=%b%b", sb[0].tag, sb[0].y, sb[0].ovf, sb[0].udf);
            void'(sb.pop_front());
        end
        if (push) begin
            e.y = v.y; e.ovf = v.ovf; e.udf = v.udf; e.tag = v.tag;
            sb.push_back(e);
            $display("push tag=%0d y=0x%08h exc=%b%b", v.tag, v.y, v.ovf, v.udf);
        end
        if (v.rst) begin
            fo_m = 1'b0; fu_m = 1'b0;
        end else begin
            fo_m = (v.flag_clear ? 1'b0 : fo_m) | (push & v.ovf);
            fu_m = (v.flag_clear ? 1'b0 : fu_m) | (push & v.udf);
        end
        if (v.rst || v.flush) sb.delete();
        @(posedge clk);
        #1;
        chk("vec_count", 32'(count), v.exp_count);
        chk("vec_out_valid", 32'(out_valid), 32'(v.exp_ov));
        chk("vec_in_ready", 32'(in_ready), 32'(v.exp_ir));
        chk("vec_flag_ovf", 32'(flag_ovf), 32'(v.exp_fo));
        chk("vec_flag_udf", 32'(flag_udf), 32'(v.exp_fu));
    endtask

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst iv y             ov ud tag ordy fl fc  cnt ov ir fo fu
        vecs[0]  = mk(1, 0, 32'h0,         0, 0, 0,  0,  0, 0,  0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 1, 32'h3F800000,  0, 0, 5,  0,  0, 0,  1, 1, 1, 0, 0);
        vecs[2]  = mk(0, 1, 32'h40000000,  0, 0, 6,  0,  0, 0,  2, 1, 1, 0, 0);
        vecs[3]  = mk(0, 1, 32'h40400000,  0, 0, 7,  0,  0, 0,  3, 1, 1, 0, 0);
        vecs[4]  = mk(0, 1, 32'h40800000,  0, 0, 8,  0,  0, 0,  4, 1, 0, 0, 0);
        vecs[5]  = mk(0, 1, 32'h40A00000,  0, 0, 9,  0,  0, 0,  4, 1, 0, 0, 0);
        vecs[6]  = mk(0, 1, 32'h40C00000,  0, 0, 10, 1,  0, 0,  3, 1, 1, 0, 0);
        vecs[7]  = mk(0, 0, 32'h0,         0, 0, 0,  1,  0, 0,  2, 1, 1, 0, 0);
        vecs[8]  = mk(0, 0, 32'h0,         0, 0, 0,  1,  0, 0,  1, 1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 32'h0,         0, 0, 0,  1,  0, 0,  0, 0, 1, 0, 0);
        vecs[10] = mk(0, 1, 32'h7F800000,  1, 0, 11, 0,  0, 1,  1, 1, 1, 1, 0);
        vecs[11] = mk(0, 0, 32'h0,         0, 0, 0,  0,  0, 1,  1, 1, 1, 0, 0);
        vecs[12] = mk(0, 1, 32'h00000001,  0, 1, 12, 0,  0, 0,  2, 1, 1, 0, 1);
        vecs[13] = mk(0, 1, 32'hC1200000,  0, 0, 13, 0,  0, 0,  3, 1, 1, 0, 1);
        vecs[14] = mk(0, 0, 32'h0,         0, 0, 0,  1,  1, 0,  0, 0, 0, 0, 1);
        vecs[15] = mk(0, 0, 32'h0,         0, 0, 0,  0,  0, 0,  0, 0, 1, 0, 1);

        // Initial reset with the reference not yet checked.
        rst = 1'b1; in_valid = 1'b0; in_y = '0; in_ovf = 1'b0; in_udf = 1'b0;
        in_tag = '0; out_ready = 1'b0; flush = 1'b0; flag_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) step(vecs[i]);

        // Fill to two, then ten cycles of simultaneous push/pop across the
        // pointer wrap: occupancy must stay at two, order preserved.
        step(mk(0, 1, 32'h3F000001, 0, 0, 20, 0, 0, 0, 1, 1, 1, 0, 1));
        step(mk(0, 1, 32'h3F000002, 1, 1, 21, 0, 0, 0, 2, 1, 1, 1, 1));
        for (int k = 0; k < 10; k++)
            step(mk(0, 1, 32'h3F000003 + k, k[0], k[1], 22 + k, 1, 0, 0, 2, 1, 1, 1, 1));

        // Reset mid-stream overrides push, pop and flag_clear.
        step(mk(1, 1, 32'hDEADBEEF, 1, 1, 40, 1, 0, 1, 0, 0, 1, 0, 0));
        step(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmul_wb_queue.md
FMUL_WB_QUEUE -- requirements
Module: fmul_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 6: destination-register tag width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  fmul result present this cycle.
REQ-007 in_ready  out  1  queue accepts a result this cycle.
REQ-008 in_y  in  32  fmul result word (IEEE single).
REQ-009 in_ovf  in  1  fmul overflow indication.
REQ-010 in_udf  in  1  fmul underflow indication.
REQ-011 in_tag  in  TAG_W  destination register of the result.
REQ-012 out_valid  out  1  head entry available for writeback.
REQ-013 out_ready  in  1  register file takes head entry.
REQ-014 out_data  out  32  head result word.
REQ-015 out_tag  out  TAG_W  head destination tag.
REQ-016 out_exc  out  2  head {ovf,udf}.
REQ-017 flush  in  1  discard all queued entries.
REQ-018 flag_clear  in  1  clear sticky exception flags.
REQ-019 flag_ovf, flag_udf  out  1 each  sticky exception flags.
REQ-020 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-021 Push SHALL occur on a cycle with in_valid && in_ready; pop on out_valid && out_ready.
REQ-022 in_ready SHALL be (count < DEPTH) && !flush; no combinational path from out_ready to in_ready.
REQ-023 A push into an empty queue SHALL appear on out_* one cycle later (latency 1, no bypass).
REQ-024 out_valid SHALL equal (count != 0); out_data/out_tag/out_exc SHALL be stable while out_valid && !out_ready.
REQ-025 Entries SHALL leave in strict push order; word, tag and exception bits SHALL pass unmodified.
REQ-026 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-027 At count == DEPTH a same-cycle pop SHALL NOT enable a push (in_ready already low).
REQ-028 Read/write pointers SHALL wrap modulo DEPTH without a bubble.
REQ-029 flush SHALL empty the queue next cycle (count=0, out_valid=0); a pop in the flush cycle is ignored; sticky flags unaffected.
REQ-030 On each accepted push, flag_ovf |= in_ovf and flag_udf |= in_udf; sticky flags SHALL also set from a push accepted during a flag_clear cycle (set wins over clear).
REQ-031 flag_clear without a simultaneous setting push SHALL zero both flags next cycle.
REQ-032 Pop of an entry SHALL NOT alter sticky flags.

Reset
REQ-033 rst SHALL, on the next rising edge, force count=0, pointers=0, out_valid=0, flag_ovf=0, flag_udf=0, in_ready=1 (post-reset, flush low).
REQ-034 rst asserted mid-stream SHALL drop all entries and override push, pop, flush and flag_clear in that cycle.
REQ-035 Storage array contents need no reset; out_data/out_tag/out_exc are don't-care while out_valid=0.

Structure
REQ-036 fpu_pkg SHALL hold TAG_W default and typedef fmul_res_t {logic [31:0] y; logic ovf; logic udf; logic [TAG_W-1:0] tag}.
REQ-037 Storage SHALL be one sub-module wb_ram (DEPTH x fmul_res_t, 1 write port, 1 async read port); pointers, count, flags stay in fmul_wb_queue.

Verification
REQ-038 After reset, push y=0x3F800000 tag=5 -> next cycle out_valid=1, out_data=0x3F800000, out_tag=5, count=1.
REQ-039 Push 4 entries with out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; pop all -> 4 words in order.
REQ-040 Full queue, out_ready=1 and in_valid=1 same cycle -> only pop, count=3; 10 continuous push/pop cycles across wrap -> order preserved, count steady.
REQ-041 Push with in_ovf=1 while flag_clear=1 -> flag_ovf=1 next cycle; later flag_clear alone -> flag_ovf=0.
REQ-042 count=3, assert flush with out_ready=1 -> next cycle count=0, out_valid=0, sticky flags unchanged.
REQ-043 rst during continuous push/pop with count=2 -> next cycle count=0, out_valid=0, flags=0, in_ready=1.
